// File: rtl/apb_backend_arbiter.sv
// apb_backend_arbiter: round-robin sharing of one register/memory backend among NUM_REQ requesters.
// Optional watchdog abort of stalled transactions when `ARB_TIMEOUT_EN is defined.
module apb_backend_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                        i_clk_apb,
   input  logic                        i_rstn_apb,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [NUM_REQ-1:0]          i_req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
   output logic [NUM_REQ-1:0]          o_req_ready,
   output logic [NUM_REQ-1:0]          o_rsp_valid,
   output logic [DATA_W-1:0]           o_rsp_rdata,
   output logic                        o_rsp_err,
   output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
   output logic                        o_busy,
   output logic                        o_valid,
   output logic                        o_rd0_wr1,
   output logic [ADDR_W-1:0]           o_addr,
   output logic [DATA_W-1:0]           o_wr_data,
   input  logic                        i_ready,
   input  logic                        i_rd_valid,
   input  logic [DATA_W-1:0]           i_rd_data
);
   localparam int          GW   = $clog2(NUM_REQ);
   localparam logic [GW:0] NREQ = (GW+1)'(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

   state_t                         r_state, w_next;
   logic [GW-1:0]                  r_rr_ptr, r_grant, w_win;
   logic                           r_valid, r_wr;
   logic [ADDR_W-1:0]              r_addr;
   logic [DATA_W-1:0]              r_wdata, r_rdata;
   logic                           w_any, w_to_fire;
   logic [2*NUM_REQ-1:0]           w_dbl;
   logic [NUM_REQ-1:0]             w_rot;
   logic [GW:0]                    w_sum, w_gnt_inc;
   logic [NUM_REQ-1:0][ADDR_W-1:0] w_addr_arr;
   logic [NUM_REQ-1:0][DATA_W-1:0] w_wdata_arr;

   assign w_addr_arr  = i_req_addr;
   assign w_wdata_arr = i_req_wdata;

   // Rotate requests so bit 0 is rr_ptr; the lowest set bit of the rotation wins.
   assign w_dbl = {i_req_valid, i_req_valid};
   assign w_rot = w_dbl[r_rr_ptr +: NUM_REQ];

   always_comb begin
      w_any = |i_req_valid;
      w_sum = '0;
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (w_rot[i]) w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
      w_win = (w_sum >= NREQ) ? GW'(w_sum - NREQ) : GW'(w_sum);
   end

   assign w_gnt_inc = {1'b0, r_grant} + (GW+1)'(1);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC+1);
   logic [CW-1:0] r_wdog;
   logic          r_err;
   logic          w_expired;

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb)                                      r_wdog <= '0;
      else if (w_next != r_state)                           r_wdog <= '0;
      else if (r_state == S_ISSUE || r_state == S_WAIT_RD)  r_wdog <= r_wdog + CW'(1);
   end

   assign w_expired = (r_state == S_ISSUE || r_state == S_WAIT_RD) &&
                      (r_wdog == CW'(TIMEOUT_CYC-1));
   // A normal completion in the expiry cycle takes priority over the abort.
   assign w_to_fire = w_expired &&
                      ((r_state == S_ISSUE && !i_ready) || (r_state == S_WAIT_RD && !i_rd_valid));

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb)              r_err <= 1'b0;
      else if (r_state == S_IDLE)   r_err <= 1'b0;
      else if (w_to_fire)           r_err <= 1'b1;
   end

   assign o_rsp_err = r_err;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^TIMEOUT_CYC;
   assign w_to_fire    = 1'b0;
   assign o_rsp_err    = 1'b0;
`endif

   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb) r_state <= S_IDLE;
      else             r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (w_any) w_next = S_ISSUE;
         S_ISSUE:   if (i_ready)        w_next = (r_wr || i_rd_valid) ? S_RESP : S_WAIT_RD;
                    else if (w_to_fire) w_next = S_RESP;
         S_WAIT_RD: if (i_rd_valid || w_to_fire) w_next = S_RESP;
         S_RESP:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_busy      = (r_state != S_IDLE);
      if (r_state == S_IDLE && w_any) o_req_ready[w_win]   = 1'b1;
      if (r_state == S_RESP)          o_rsp_valid[r_grant] = 1'b1;
   end

   // Command latch doubles as the registered backend drive; cleared on the way back to IDLE.
   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb) begin
         r_valid  <= 1'b0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_any) begin
               r_valid <= 1'b1;
               r_wr    <= i_req_wr[w_win];
               r_addr  <= w_addr_arr[w_win];
               r_wdata <= w_wdata_arr[w_win];
               r_rdata <= '0;
               r_grant <= w_win;
            end
            S_ISSUE: if (i_ready) begin
               r_valid <= 1'b0;
               if (!r_wr && i_rd_valid) r_rdata <= i_rd_data;
            end else if (w_to_fire) begin
               r_valid <= 1'b0;
            end
            S_WAIT_RD: if (i_rd_valid) r_rdata <= i_rd_data;
            S_RESP: begin
               r_wr     <= 1'b0;
               r_addr   <= '0;
               r_wdata  <= '0;
               r_rr_ptr <= (w_gnt_inc >= NREQ) ? '0 : GW'(w_gnt_inc);
            end
            default: ;
         endcase
      end
   end

   assign o_valid     = r_valid;
   assign o_rd0_wr1   = r_wr;
   assign o_addr      = r_addr;
   assign o_wr_data   = r_wdata;
   assign o_rsp_rdata = r_rdata;
   assign o_grant_id  = r_grant;

endmodule

// File: tb/tb_apb_backend_arbiter.sv
// Scoreboard bench for apb_backend_arbiter: stimulus queues expected completions, a monitor checks them.
module tb_apb_backend_arbiter;
   localparam int NR = 2;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NR-1:0]       req_valid = '0;
   logic [NR-1:0]       req_wr = '0;
   logic [NR-1:0][31:0] req_addr = '0;
   logic [NR-1:0][31:0] req_wdata = '0;
   logic [NR-1:0]       o_req_ready, o_rsp_valid;
   logic [31:0]         o_rsp_rdata, o_addr, o_wr_data;
   logic                o_rsp_err, o_busy, o_valid, o_rd0_wr1;
   logic [0:0]          o_grant_id;
   logic                be_ready = 1'b0, be_rd_valid = 1'b0;
   logic [31:0]         be_rd_data = '0;

   int   n_chk = 0, n_pass = 0;
   rsp_t exp_q[$];
   rsp_t e_mon;

   apb_backend_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .i_clk_apb(clk), .i_rstn_apb(rst_n),
      .i_req_valid(req_valid), .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
      .o_rsp_err(o_rsp_err), .o_grant_id(o_grant_id), .o_busy(o_busy),
      .o_valid(o_valid), .o_rd0_wr1(o_rd0_wr1), .o_addr(o_addr), .o_wr_data(o_wr_data),
      .i_ready(be_ready), .i_rd_valid(be_rd_valid), .i_rd_data(be_rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input int id, input logic [31:0] rd, input logic err);
      rsp_t r;
      r.id = id; r.rdata = rd; r.err = err;
      exp_q.push_back(r);
   endtask

   task automatic drain(input string nm);
      int c = 0;
      while (exp_q.size() != 0 && c < 50) begin tick(); c++; end
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_valid"}, o_valid, 0);
      chk({nm, "_addr"},  o_addr, 0);
      chk({nm, "_wdata"}, o_wr_data, 0);
      chk({nm, "_dir"},   o_rd0_wr1, 0);
      chk({nm, "_busy"},  o_busy, 0);
      chk({nm, "_gid"},   o_grant_id, 0);
      chk({nm, "_rspv"},  o_rsp_valid, 0);
      chk({nm, "_rdata"}, o_rsp_rdata, 0);
      chk({nm, "_err"},   o_rsp_err, 0);
      chk({nm, "_rdy"},   o_req_ready, 0);
   endtask

   // Completion monitor: every o_rsp_valid must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && o_rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: o_rsp_valid=%b expected none", o_rsp_valid);
         end else begin
            e_mon = exp_q.pop_front();
            chk("rsp_valid", o_rsp_valid, 64'(1) << e_mon.id);
            chk("rsp_rdata", o_rsp_rdata, e_mon.rdata);
            chk("rsp_err",   o_rsp_err,   e_mon.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, k;
      logic [NR-1:0] exp_oh [4];

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst");
      tick(); rst_n = 1'b1;

      // reset mid-ISSUE drops the transaction
      tick(); req_valid = 2'b10; req_wr = 2'b10; req_addr[1] = 32'h70; req_wdata[1] = 32'h77;
      @(negedge clk); chk("t1_rdy", o_req_ready, 2'b10);
      tick(); req_valid = '0;
      @(negedge clk); chk("t1_issue_valid", o_valid, 1); chk("t1_gid", o_grant_id, 1);
      tick(); rst_n = 1'b0;
      @(negedge clk); chk_all_zero("t1_midrst");
      tick(); tick(); rst_n = 1'b1;
      repeat (4) tick();

      // req0 write, with req1 also asserting: rr_ptr restarts at 0
      req_valid = 2'b11; req_wr = 2'b11;
      req_addr[0] = 32'h10; req_wdata[0] = 32'hA5A5_0001;
      be_ready = 1'b1;
      push(0, 32'h0, 1'b0);
      @(negedge clk); chk("t2_rdy", o_req_ready, 2'b01);
      tick(); req_valid = '0;
      @(negedge clk);
      chk("t2_valid", o_valid, 1); chk("t2_dir", o_rd0_wr1, 1);
      chk("t2_addr", o_addr, 32'h10); chk("t2_wdata", o_wr_data, 32'hA5A5_0001);
      chk("t2_gid", o_grant_id, 0);
      tick();
      @(negedge clk); chk("t2_rspv", o_rsp_valid, 2'b01);
      tick(); be_ready = 1'b0;
      @(negedge clk); chk("t2_idle_addr", o_addr, 0);
      drain("t2_drain");

      // req1 read with a 3-cycle backend data delay
      tick(); req_valid = 2'b10; req_wr = 2'b00; req_addr[1] = 32'h20;
      push(1, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk); chk("t3_rdy", o_req_ready, 2'b10);
      tick(); req_valid = '0; be_ready = 1'b1;
      @(negedge clk); chk("t3_valid", o_valid, 1); chk("t3_dir", o_rd0_wr1, 0); chk("t3_addr", o_addr, 32'h20);
      tick(); be_ready = 1'b0;
      @(negedge clk); chk("t3_wait_valid", o_valid, 0); chk("t3_busy2", o_busy, 1);
      tick(); @(negedge clk); chk("t3_busy3", o_busy, 1);
      tick(); be_rd_valid = 1'b1; be_rd_data = 32'hDEAD_BEEF;
      @(negedge clk); chk("t3_busy4", o_busy, 1);
      tick(); be_rd_valid = 1'b0; be_rd_data = '0;
      @(negedge clk); chk("t3_busy5", o_busy, 1);
      tick(); @(negedge clk); chk("t3_idle", o_busy, 0);
      drain("t3_drain");

      // both requesters held: strict rotation 0,1,0,1
      exp_oh[0] = 2'b01; exp_oh[1] = 2'b10; exp_oh[2] = 2'b01; exp_oh[3] = 2'b10;
      tick(); req_valid = 2'b11; req_wr = 2'b11;
      req_addr[0] = 32'h40; req_wdata[0] = 32'h1; req_addr[1] = 32'h50; req_wdata[1] = 32'h2;
      be_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(i % 2, 32'h0, 1'b0);
      k = 0;
      for (int c = 0; c < 30 && k < 4; c++) begin
         @(negedge clk);
         if (o_req_ready != '0) begin
            chk("t4_rdy", o_req_ready, exp_oh[k]);
            tick();
            if (k == 3) req_valid = '0;
            @(negedge clk);
            chk("t4_gid", o_grant_id, k % 2);
            chk("t4_addr", o_addr, (k % 2 == 0) ? 32'h40 : 32'h50);
            k++;
         end
         tick();
      end
      chk("t4_count", k, 4);
      req_valid = '0;
      drain("t4_drain");
      be_ready = 1'b0;

      // read accepted with data in the same cycle skips WAIT_RD
      tick(); req_valid = 2'b01; req_wr = 2'b00; req_addr[0] = 32'h30;
      push(0, 32'h1234_5678, 1'b0);
      @(negedge clk); chk("t5_rdy", o_req_ready, 2'b01);
      tick(); req_valid = '0; be_ready = 1'b1; be_rd_valid = 1'b1; be_rd_data = 32'h1234_5678;
      @(negedge clk); chk("t5_valid", o_valid, 1);
      tick(); be_ready = 1'b0; be_rd_valid = 1'b0; be_rd_data = '0;
      @(negedge clk); chk("t5_rspv", o_rsp_valid, 2'b01);
      drain("t5_drain");

      // stalled backend
      tick(); req_valid = 2'b10; req_wr = 2'b10; req_addr[1] = 32'h60; req_wdata[1] = 32'h66;
`ifdef ARB_TIMEOUT_EN
      push(1, 32'h0, 1'b1);
`endif
      @(negedge clk); chk("t6_rdy", o_req_ready, 2'b10);
      tick(); req_valid = '0;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (o_valid) cnt++;
         tick();
      end
`ifdef ARB_TIMEOUT_EN
      chk("t6_valid_cycles", cnt, 8);
      drain("t6_drain");
`else
      chk("t6_valid_cycles", cnt, 12);
      chk("t6_busy", o_busy, 1);
      rst_n = 1'b0;
      tick(); tick(); rst_n = 1'b1;
      repeat (3) tick();
`endif
      repeat (3) tick();
      chk("final_queue", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
